// File: rtl/seq_control_unit.sv
// seq_control_unit: sequential instruction decoder for the 9-bit ISA.
// Decodes the instruction word each cycle, owns the architectural compare flag,
// stretches loads over MEM_LAT cycles with PCEn held low, and latches DONE as a
// sticky halt. All decode outputs are combinational from state and instr.
module seq_control_unit #(
   parameter int OPW     = 9,
   parameter int RAW     = 4,
   parameter int ALUOPW  = 5,
   parameter int MEM_LAT = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [OPW-1:0]    instr,
   input  logic              instr_valid,
   input  logic              eq_in,
   input  logic              lt_in,
   output logic [RAW-1:0]    ReadAddr1,
   output logic [RAW-1:0]    ReadAddr2,
   output logic [RAW-1:0]    WriteAddr,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              MemtoReg,
   output logic              ALUSrc,
   output logic [ALUOPW-1:0] ALUOp,
   output logic [7:0]        Imm,
   output logic              BranchTaken,
   output logic [4:0]        BranchIdx,
   output logic              PCEn,
   output logic              Flag,
   output logic              Halt,
   output logic              Illegal
);

   typedef enum logic [1:0] {
      S_RUN,
      S_MEMWAIT,
      S_HALT
   } state_t;

   // Counter is preloaded so that the final wait cycle is the one with count 1.
   localparam logic [3:0] LOAD_WAIT = 4'(MEM_LAT - 1);

   localparam logic [8:0] OP_DONE = 9'b111111111;
   localparam logic [8:0] OP_NOP  = 9'b111111110;

   state_t     state, state_next;
   logic       flag_q, flag_next;
   logic [3:0] cnt, cnt_next;
   logic [8:0] op;

   // Only the low nine bits carry fields; wider instruction words are ignored above.
   assign op        = instr[8:0];
   assign Imm       = op[7:0];
   assign BranchIdx = op[4:0];
   assign Flag      = flag_q;

   // State, compare flag and load-wait counter registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state  <= S_RUN;
         flag_q <= 1'b0;
         cnt    <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state  <= state_next;
         flag_q <= flag_next;
         cnt    <= cnt_next;
      end
   end

   // Next-state, next-flag, counter update and all decode outputs.
   always_comb begin
      // NOTE: every output gets its default first, so no path can infer a latch.
      ReadAddr1   = '0;
      ReadAddr2   = RAW'(1);
      WriteAddr   = '0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrc      = 1'b0;
      ALUOp       = '1;
      BranchTaken = 1'b0;
      PCEn        = 1'b0;
      Halt        = 1'b0;
      Illegal     = 1'b0;
      state_next  = state;
      flag_next   = flag_q;
      cnt_next    = cnt;

      // While reset is held the outputs stay at their defaults.
      if (Reset) begin
         case (state)
            S_RUN: begin
               if (instr_valid) begin
                  PCEn = 1'b1;
                  if (op == OP_DONE) begin
                     state_next = S_HALT;
                  end else if (op == OP_NOP) begin
                     // defaults plus PC advance
                  end else if (op[8:5] == 4'b1110) begin
                     if (op[4:3] != 2'b11) begin
                        case (op[4:2])
                           3'b000:  ALUOp = ALUOPW'(5'b00100);
                           3'b001:  ALUOp = ALUOPW'(5'b00101);
                           3'b010:  ALUOp = ALUOPW'(5'b00000);
                           3'b011:  ALUOp = ALUOPW'(5'b00001);
                           3'b100:  ALUOp = ALUOPW'(5'b00010);
                           default: ALUOp = ALUOPW'(5'b00011);
                        endcase
                        WriteAddr = RAW'(op[1:0]);
                        RegWrite  = 1'b1;
                     end else if (op[1:0] == 2'b00) begin
                        flag_next = op[2] ? lt_in : eq_in;
                     end else begin
                        // malformed compare executes as a NOP and leaves the flag alone
                        Illegal = 1'b1;
                     end
                  end else if (op[8:6] == 3'b110) begin
                     BranchTaken = op[5] ? flag_q : 1'b1;
                     if (op[5] && flag_q) begin
                        flag_next = 1'b0;
                     end
                  end else if (op[8:7] == 2'b10) begin
                     ReadAddr1 = RAW'(op[5:4]);
                     if (op[6]) begin
                        MemWrite = 1'b1;
                     end else begin
                        WriteAddr = RAW'(op[5:4]);
                        if (MEM_LAT == 1) begin
                           RegWrite = 1'b1;
                           MemtoReg = 1'b1;
                        end else begin
                           PCEn       = 1'b0;
                           cnt_next   = LOAD_WAIT;
                           state_next = S_MEMWAIT;
                        end
                     end
                  end else if (!op[8]) begin
                     ALUSrc    = 1'b1;
                     ALUOp     = ALUOPW'(5'b00110);
                     WriteAddr = '0;
                     RegWrite  = 1'b1;
                  end else begin
                     Illegal = 1'b1;
                  end
               end
            end

            S_MEMWAIT: begin
               // instr is held stable by the PC, so the load fields are still valid
               ReadAddr1 = RAW'(op[5:4]);
               WriteAddr = RAW'(op[5:4]);
               cnt_next  = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  RegWrite   = 1'b1;
                  MemtoReg   = 1'b1;
                  PCEn       = 1'b1;
                  state_next = S_RUN;
               end
            end

            S_HALT: begin
               Halt = 1'b1;
            end

            default: begin
               state_next = S_RUN;
            end
         endcase
      end
   end

endmodule
